// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache.
// Contents:
//   MEM_WORD_W - width of a memory word and of a byte address
//   state_t    - controller FSM states
//   idx_of()   - line index taken from a byte address
//   tag_of()   - tag taken from a byte address
package dcache_pkg;

  localparam int MEM_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    RD_DONE = 2'd2,
    WR_THRU = 2'd3
  } state_t;

  // Line index: word-address bits just above the byte offset.
  // The caller narrows the result to its own index width.
  function automatic logic [MEM_WORD_W-1:0] idx_of(input logic [MEM_WORD_W-1:0] addr,
                                                   input int idxW);
    return (addr >> 2) & ((32'd1 << idxW) - 32'd1);
  endfunction

  // Tag: every address bit above the index field.
  function automatic logic [MEM_WORD_W-1:0] tag_of(input logic [MEM_WORD_W-1:0] addr,
                                                   input int idxW);
    return addr >> (2 + idxW);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Bus bundle for the data cache: core-side request port, backing-memory
// port and statistics counters.
// Modports:
//   slave  - the cache (takes core requests and memory responses,
//            drives load data, stall, memory requests and counters)
//   master - the environment (core plus backing memory)
// Signals:
//   memreadM, memwriteM, memaddra, memwdata - core request
//   rdata, stall                            - core response
//   mem_req, mem_we, mem_addr, mem_wdata    - backing-memory request
//   mem_ack, mem_rdata                      - backing-memory response
//   hit_cnt, miss_cnt                       - load statistics
interface dcache_if #(
  parameter int CNT_W = 16
) ();
  import dcache_pkg::*;

  logic                  memreadM;
  logic                  memwriteM;
  logic [MEM_WORD_W-1:0] memaddra;
  logic [MEM_WORD_W-1:0] memwdata;
  logic [MEM_WORD_W-1:0] rdata;
  logic                  stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [MEM_WORD_W-1:0] mem_addr;
  logic [MEM_WORD_W-1:0] mem_wdata;
  logic                  mem_ack;
  logic [MEM_WORD_W-1:0] mem_rdata;

  logic [CNT_W-1:0]      hit_cnt;
  logic [CNT_W-1:0]      miss_cnt;

  modport slave (
    input  memreadM, memwriteM, memaddra, memwdata, mem_ack, mem_rdata,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  modport master (
    output memreadM, memwriteM, memaddra, memwdata, mem_ack, mem_rdata,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/dcache_tag_data_ram.sv
// Tag, data and valid storage for a direct-mapped cache with one word per
// line. Reads are asynchronous, writes happen on the rising clock edge.
// Only the valid bits are reset; tag and data contents are left as-is.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   rdIdx_i    - lookup index
//   rdValid_o  - valid bit of the looked-up line
//   rdTag_o    - stored tag of the looked-up line
//   rdData_o   - stored data of the looked-up line
//   wrIdx_i    - write index
//   wrTag_i    - tag written on a fill
//   wrData_i   - data written on a fill or a store hit
//   dataWe_i   - store-hit update: data only
//   fillWe_i   - line fill: data, tag and valid bit
module dcache_tag_data_ram
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = MEM_WORD_W - 2 - IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      rdIdx_i,
  output logic                  rdValid_o,
  output logic [TAG_W-1:0]      rdTag_o,
  output logic [MEM_WORD_W-1:0] rdData_o,
  input  logic [IDX_W-1:0]      wrIdx_i,
  input  logic [TAG_W-1:0]      wrTag_i,
  input  logic [MEM_WORD_W-1:0] wrData_i,
  input  logic                  dataWe_i,
  input  logic                  fillWe_i
);

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tagMem  [LINES];
  logic [MEM_WORD_W-1:0] dataMem [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fillWe_i) begin
      valid_q[wrIdx_i] <= 1'b1;
    end
  end

  // Arrays carry no reset so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fillWe_i) begin
      tagMem[wrIdx_i] <= wrTag_i;
    end
    if (fillWe_i || dataWe_i) begin
      dataMem[wrIdx_i] <= wrData_i;
    end
  end

  assign rdValid_o = valid_q[rdIdx_i];
  assign rdTag_o   = tagMem[rdIdx_i];
  assign rdData_o  = dataMem[rdIdx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Answers core loads from the cache when possible, fetches misses from
// backing memory, forwards every store to backing memory and stalls the
// core while a backing-memory transaction is outstanding.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - dcache_if.slave: core request/response, backing-memory
//          request/response and hit/miss counters
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  dcache_if.slave  bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = MEM_WORD_W - 2 - IDX_W;

  state_t state_q, state_d;

  logic                  memReq_q;
  logic                  memWe_q;
  logic [MEM_WORD_W-1:0] memAddr_q;
  logic [MEM_WORD_W-1:0] memWdata_q;
  logic [MEM_WORD_W-1:0] rdata_q;
  logic [CNT_W-1:0]      hitCnt_q;
  logic [CNT_W-1:0]      missCnt_q;

  logic [IDX_W-1:0]      reqIdx;
  logic [TAG_W-1:0]      reqTag;
  logic [IDX_W-1:0]      fillIdx;
  logic [TAG_W-1:0]      fillTag;

  logic                  rdValid;
  logic [TAG_W-1:0]      rdTag;
  logic [MEM_WORD_W-1:0] rdData;
  logic                  lookupHit;
  logic                  isStore;
  logic                  isLoad;

  logic                  stallComb;
  logic [MEM_WORD_W-1:0] rdataComb;
  logic                  dataWe;
  logic                  fillWe;
  logic [IDX_W-1:0]      wrIdx;
  logic [MEM_WORD_W-1:0] wrData;
  logic                  countHit;
  logic                  countMiss;
  logic                  issueRead;
  logic                  issueWrite;
  logic                  ackSeen;

  assign reqIdx = IDX_W'(idx_of(bus.memaddra, IDX_W));
  assign reqTag = TAG_W'(tag_of(bus.memaddra, IDX_W));

  // A fill uses the address captured when the miss was issued, so it does
  // not depend on the core keeping memaddra steady.
  assign fillIdx = IDX_W'(idx_of(memAddr_q, IDX_W));
  assign fillTag = TAG_W'(tag_of(memAddr_q, IDX_W));

  assign lookupHit = rdValid && (rdTag == reqTag);

  // A simultaneous read and write is treated as a store only.
  assign isStore = bus.memwriteM;
  assign isLoad  = bus.memreadM && !bus.memwriteM;

  dcache_tag_data_ram #(
    .LINES (LINES)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .rdIdx_i   (reqIdx),
    .rdValid_o (rdValid),
    .rdTag_o   (rdTag),
    .rdData_o  (rdData),
    .wrIdx_i   (wrIdx),
    .wrTag_i   (fillTag),
    .wrData_i  (wrData),
    .dataWe_i  (dataWe),
    .fillWe_i  (fillWe)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (isStore) begin
          state_d = WR_THRU;
        end else if (isLoad && !lookupHit) begin
          state_d = RD_MISS;
        end
      end
      RD_MISS: begin
        if (bus.mem_ack) begin
          state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      WR_THRU: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Core-facing response and per-cycle control strobes.
  always_comb begin
    stallComb  = 1'b0;
    rdataComb  = rdata_q;
    dataWe     = 1'b0;
    fillWe     = 1'b0;
    wrIdx      = reqIdx;
    wrData     = bus.memwdata;
    countHit   = 1'b0;
    countMiss  = 1'b0;
    issueRead  = 1'b0;
    issueWrite = 1'b0;
    ackSeen    = 1'b0;
    case (state_q)
      IDLE: begin
        if (isStore) begin
          stallComb  = 1'b1;
          issueWrite = 1'b1;
          dataWe     = lookupHit;
        end else if (isLoad) begin
          if (lookupHit) begin
            rdataComb = rdData;
            countHit  = 1'b1;
          end else begin
            stallComb = 1'b1;
            countMiss = 1'b1;
            issueRead = 1'b1;
          end
        end
      end
      RD_MISS: begin
        stallComb = 1'b1;
        wrIdx     = fillIdx;
        wrData    = bus.mem_rdata;
        if (bus.mem_ack) begin
          fillWe  = 1'b1;
          ackSeen = 1'b1;
        end
      end
      RD_DONE: begin
        stallComb = 1'b0;
      end
      WR_THRU: begin
        // The store completes in its ack cycle, so the core is released
        // without waiting for the return to IDLE.
        stallComb = !bus.mem_ack;
        ackSeen   = bus.mem_ack;
      end
      default: begin
        stallComb = 1'b0;
      end
    endcase
  end

  // Backing-memory request registers, load-data latch and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      rdata_q    <= '0;
      hitCnt_q   <= '0;
      missCnt_q  <= '0;
    end else begin
      if (issueRead) begin
        memReq_q  <= 1'b1;
        memWe_q   <= 1'b0;
        memAddr_q <= {bus.memaddra[MEM_WORD_W-1:2], 2'b00};
      end
      if (issueWrite) begin
        memReq_q   <= 1'b1;
        memWe_q    <= 1'b1;
        memAddr_q  <= {bus.memaddra[MEM_WORD_W-1:2], 2'b00};
        memWdata_q <= bus.memwdata;
      end
      if (ackSeen) begin
        memReq_q <= 1'b0;
      end
      if (fillWe) begin
        rdata_q <= bus.mem_rdata;
      end
      if (countHit) begin
        hitCnt_q <= hitCnt_q + CNT_W'(1);
      end
      if (countMiss) begin
        missCnt_q <= missCnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall     = stallComb;
  assign bus.rdata     = rdataComb;
  assign bus.mem_req   = memReq_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.hit_cnt   = hitCnt_q;
  assign bus.miss_cnt  = missCnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard testbench for dcache_ctrl. Stimulus pushes expected load data
// and expected backing-memory requests into queues; independent monitor
// processes pop and compare when the DUT completes a load or raises
// mem_req. A backing-memory model acks after a programmable delay.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memExp_t;

  logic clk;
  logic rst;

  dcache_if #(.CNT_W(16)) bus ();

  dcache_ctrl #(
    .LINES (16),
    .CNT_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] loadQ[$];
  memExp_t     memQ[$];

  bit          memEnable   = 1'b1;
  int          memAckDelay = 1;
  logic [31:0] memRdataVal = '0;
  int          reqCnt      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Record a DUT event that had no matching expectation.
  task automatic reportUnexpected(input string name, input logic [31:0] actual);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: got 0x%08h, expected nothing", name, actual);
  endtask

  // Issue one core request, push its expected results, hold it until the
  // cache releases stall, and check how many cycles stall was high.
  // Called and returns 1 time unit after a rising edge.
  task automatic applyStimulus(input string name, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input bit expMem, input int ackDelay,
                               input logic [31:0] memData, input logic [31:0] expRdata,
                               input int expStall);
    memExp_t e;
    int      stallCnt;
    bit      done;
    if (expMem) begin
      e.we    = wr;
      e.addr  = {addr[31:2], 2'b00};
      e.wdata = wdata;
      memQ.push_back(e);
    end
    if (rd && !wr) begin
      loadQ.push_back(expRdata);
    end
    memAckDelay   = ackDelay;
    memRdataVal   = memData;
    bus.memreadM  = rd;
    bus.memwriteM = wr;
    bus.memaddra  = addr;
    bus.memwdata  = wdata;
    stallCnt = 0;
    done     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.stall) begin
        stallCnt++;
      end else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      reportUnexpected({name, " stall never released"}, 32'(stallCnt));
    end
    checkOutput({name, " stall cycles"}, 32'(stallCnt), 32'(expStall));
    @(posedge clk);
    #1;
    bus.memreadM  = 1'b0;
    bus.memwriteM = 1'b0;
  endtask

  // Backing memory: counts cycles with mem_req high, checks the request
  // fields when it first rises, and acks in the programmed cycle.
  initial begin
    memExp_t e;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        reqCnt++;
        if (reqCnt == 1) begin
          if (memQ.size() == 0) begin
            reportUnexpected("mem_req address", bus.mem_addr);
          end else begin
            e = memQ.pop_front();
            checkOutput("mem_we", 32'(bus.mem_we), 32'(e.we));
            checkOutput("mem_addr", bus.mem_addr, e.addr);
            if (e.we) begin
              checkOutput("mem_wdata", bus.mem_wdata, e.wdata);
            end
          end
        end
        if (memEnable) begin
          bus.mem_ack   = (reqCnt == memAckDelay);
          bus.mem_rdata = (reqCnt == memAckDelay) ? memRdataVal : 32'h0;
        end
      end else begin
        reqCnt = 0;
        if (memEnable) begin
          bus.mem_ack = 1'b0;
        end
      end
    end
  end

  // Load-response monitor: a load completes in any cycle it is presented
  // with stall low.
  initial begin
    logic [31:0] expData;
    forever begin
      @(negedge clk);
      if (!rst && bus.memreadM && !bus.memwriteM && !bus.stall) begin
        if (loadQ.size() == 0) begin
          reportUnexpected("load rdata", bus.rdata);
        end else begin
          expData = loadQ.pop_front();
          checkOutput("load rdata", bus.rdata, expData);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.memreadM  = 1'b0;
    bus.memwriteM = 1'b0;
    bus.memaddra  = '0;
    bus.memwdata  = '0;
    repeat (3) @(negedge clk);

    checkOutput("reset rdata", bus.rdata, 32'h0);
    checkOutput("reset stall", 32'(bus.stall), 32'h0);
    checkOutput("reset mem_req", 32'(bus.mem_req), 32'h0);
    checkOutput("reset mem_we", 32'(bus.mem_we), 32'h0);
    checkOutput("reset mem_addr", bus.mem_addr, 32'h0);
    checkOutput("reset mem_wdata", bus.mem_wdata, 32'h0);
    checkOutput("reset hit_cnt", 32'(bus.hit_cnt), 32'h0);
    checkOutput("reset miss_cnt", 32'(bus.miss_cnt), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss with ack in the third mem_req cycle.
    applyStimulus("t1 load 0x40", 1, 0, 32'h40, 32'h0, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF, 4);
    checkOutput("t1 miss_cnt", 32'(bus.miss_cnt), 32'd1);
    checkOutput("t1 hit_cnt", 32'(bus.hit_cnt), 32'd0);

    applyStimulus("t2 load 0x40", 1, 0, 32'h40, 32'h0, 0, 1, 32'h0, 32'hDEADBEEF, 0);
    checkOutput("t2 hit_cnt", 32'(bus.hit_cnt), 32'd1);

    // Store hit updates the line and goes through to memory.
    applyStimulus("t3 store 0x40", 0, 1, 32'h40, 32'h12345678, 1, 1, 32'h0, 32'h0, 1);
    applyStimulus("t3 load 0x40", 1, 0, 32'h40, 32'h0, 0, 1, 32'h0, 32'h12345678, 0);
    checkOutput("t3 hit_cnt", 32'(bus.hit_cnt), 32'd2);

    // Store miss does not allocate.
    applyStimulus("t4 store 0x80", 0, 1, 32'h80, 32'hCAFEF00D, 1, 2, 32'h0, 32'h0, 2);
    applyStimulus("t4 load 0x80", 1, 0, 32'h80, 32'h0, 1, 1, 32'hCAFEF00D, 32'hCAFEF00D, 2);
    checkOutput("t4 miss_cnt", 32'(bus.miss_cnt), 32'd2);

    // Conflict misses on line 0.
    applyStimulus("t5 load 0x40", 1, 0, 32'h40, 32'h0, 1, 1, 32'h12345678, 32'h12345678, 2);
    applyStimulus("t5 load 0x440", 1, 0, 32'h440, 32'h0, 1, 2, 32'h44044044, 32'h44044044, 3);
    applyStimulus("t5 reload 0x40", 1, 0, 32'h40, 32'h0, 1, 1, 32'h12345678, 32'h12345678, 2);
    checkOutput("t5 miss_cnt", 32'(bus.miss_cnt), 32'd5);
    checkOutput("t5 hit_cnt", 32'(bus.hit_cnt), 32'd2);

    // Last line, byte-offset bits ignored, read+write priority.
    applyStimulus("x load 0x3C", 1, 0, 32'h3C, 32'h0, 1, 2, 32'h0F0F0F0F, 32'h0F0F0F0F, 3);
    applyStimulus("x load 0x3E", 1, 0, 32'h3E, 32'h0, 0, 1, 32'h0, 32'h0F0F0F0F, 0);
    applyStimulus("x load 0x46", 1, 0, 32'h46, 32'h0, 1, 1, 32'h46464646, 32'h46464646, 2);
    applyStimulus("x rdwr 0x3C", 1, 1, 32'h3C, 32'hA5A5A5A5, 1, 1, 32'h0, 32'h0, 1);
    applyStimulus("x load 0x3C", 1, 0, 32'h3C, 32'h0, 0, 1, 32'h0, 32'hA5A5A5A5, 0);
    checkOutput("x hit_cnt", 32'(bus.hit_cnt), 32'd4);
    checkOutput("x miss_cnt", 32'(bus.miss_cnt), 32'd7);

    // Reset while a miss is outstanding; memory never acks in time.
    memEnable = 1'b0;
    begin
      memExp_t e;
      e.we    = 1'b0;
      e.addr  = 32'h100;
      e.wdata = 32'h0;
      memQ.push_back(e);
    end
    bus.memreadM = 1'b1;
    bus.memaddra = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t6 mem_req in RD_MISS", 32'(bus.mem_req), 32'h1);
    checkOutput("t6 stall in RD_MISS", 32'(bus.stall), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6 mem_req after rst", 32'(bus.mem_req), 32'h0);
    checkOutput("t6 mem_addr after rst", bus.mem_addr, 32'h0);
    checkOutput("t6 miss_cnt after rst", 32'(bus.miss_cnt), 32'h0);
    checkOutput("t6 hit_cnt after rst", 32'(bus.hit_cnt), 32'h0);
    bus.memreadM = 1'b0;
    #1;
    checkOutput("t6 stall after rst", 32'(bus.stall), 32'h0);
    checkOutput("t6 rdata after rst", bus.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    checkOutput("t6 stall on late ack", 32'(bus.stall), 32'h0);
    @(posedge clk);
    #1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    checkOutput("t6 mem_req after late ack", 32'(bus.mem_req), 32'h0);
    checkOutput("t6 rdata after late ack", bus.rdata, 32'h0);
    memEnable = 1'b1;
    applyStimulus("t6 reload 0x40", 1, 0, 32'h40, 32'h0, 1, 1, 32'h12345678, 32'h12345678, 2);
    checkOutput("t6 miss_cnt", 32'(bus.miss_cnt), 32'd1);
    checkOutput("t6 hit_cnt", 32'(bus.hit_cnt), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("load queue drained", 32'(loadQ.size()), 32'd0);
    checkOutput("mem queue drained", 32'(memQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
